// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - ctrl-word layout, device address default and FSM encoding shared by the EEPROM sequencer
package i2c_pkg;

  localparam int ADDR_LSB = 0;
  localparam int DEV_LSB  = 8;
  localparam int RW_BIT   = 16;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACC,
    ST_WAIT_DONE,
    ST_TWR,
    ST_RD_OUT,
    ST_DONE
  } seq_state_e;

  function automatic logic [31:0] make_ctrl(input logic rw, input logic [6:0] dev,
                                            input logic [7:0] addr);
    logic [31:0] w;
    w                = '0;
    w[ADDR_LSB +: 8] = addr;
    w[DEV_LSB +: 7]  = dev;
    w[RW_BIT]        = rw;
    return w;
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// rtl/i2c_seq_timer.sv - loadable down-counter with zero flag, shared by the tWR hold-off and accept watchdog
module i2c_seq_timer #(
  parameter int W = 20
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Saturates at zero so a caller that keeps enable high simply sees zero stay asserted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_eeprom_seq.sv
// rtl/i2c_eeprom_seq.sv - splits a byte burst into single-byte AT24C02 transactions on the I2C master core
module i2c_eeprom_seq
  import i2c_pkg::*;
#(
  parameter int         MAX_LEN  = 16,
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         TWR_CYC  = 500000,
  parameter int         ACC_TMO  = 1024,
  parameter int         LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err,
  output logic [31:0]      m_ctrl,
  output logic [31:0]      m_wdata,
  output logic             m_start,
  input  logic [31:0]      m_rdata,
  input  logic             m_idle
);

  localparam int TMR_MAX = (TWR_CYC > ACC_TMO) ? TWR_CYC : ACC_TMO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  seq_state_e       state_q, state_d;
  logic             rw_q;
  logic [7:0]       addr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [7:0]       wbyte_q;
  logic             len_bad;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;
  logic             on_bus;
  logic             unused_rdata;

  assign len_bad      = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
  assign unused_rdata = ^m_rdata[31:8];

  i2c_seq_timer #(.W(TMR_W)) u_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    on_bus    = 1'b0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    m_start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (len_bad)     state_d = ST_DONE;
          else if (cmd_rw) state_d = ST_ISSUE;
          else             state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        on_bus   = 1'b1;
        m_start  = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(ACC_TMO - 1);
        state_d  = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        on_bus = 1'b1;
        if (!m_idle)       state_d = ST_WAIT_DONE;
        else if (tmr_zero) state_d = ST_DONE;
        else               tmr_en  = 1'b1;
      end
      ST_WAIT_DONE: begin
        on_bus = 1'b1;
        if (m_idle) begin
          if (rw_q) begin
            state_d = ST_RD_OUT;
          end else begin
            state_d  = ST_TWR;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TWR_CYC - 1);
          end
        end
      end
      ST_TWR: begin
        // cnt_q already reflects the byte just written.
        if (tmr_zero) state_d = (cnt_q == '0) ? ST_DONE : ST_FETCH;
        else          tmr_en  = 1'b1;
      end
      ST_RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) state_d = (cnt_q == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wbyte_q <= '0;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && cmd_valid) begin
        rw_q   <= cmd_rw;
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
        err    <= len_bad;
      end
      if ((state_q == ST_FETCH) && wr_valid) begin
        wbyte_q <= wr_data;
      end
      if ((state_q == ST_WAIT_ACC) && m_idle && tmr_zero) begin
        err <= 1'b1;
      end
      if ((state_q == ST_WAIT_DONE) && m_idle) begin
        addr_q <= addr_q + 8'd1;
        cnt_q  <= cnt_q - 1'b1;
        if (rw_q) rd_data <= m_rdata[7:0];
      end
    end
  end

  // Words are derived from registers that only move after WAIT_DONE, so they stay stable on the bus.
  assign m_ctrl  = on_bus ? make_ctrl(rw_q, DEV_ADDR, addr_q) : '0;
  assign m_wdata = (on_bus && !rw_q) ? {24'h0, wbyte_q} : '0;

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// tb/tb_i2c_eeprom_seq.sv - directed bench with behavioural I2C master and scoreboard queues
module tb_i2c_eeprom_seq;

  localparam int MAX_LEN = 16;
  localparam int TWR     = 20;
  localparam int TMO     = 64;
  localparam int LW      = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] wdata;
    logic        is_wr;
  } exp_t;

  logic          aclk, aresetn;
  logic          cmd_valid, cmd_ready, cmd_rw;
  logic [7:0]    cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [7:0]    wr_data;
  logic          rd_valid, rd_ready;
  logic [7:0]    rd_data;
  logic          done, err;
  logic [31:0]   m_ctrl, m_wdata, m_rdata;
  logic          m_start, m_idle;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   starts = 0;
  int   last_start = 0;
  int   last_rise = 0;
  bit   hang = 0;
  bit   mbusy = 0;
  bit   prev_wr = 0;
  int   mcnt = 0;
  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] wq[$];

  i2c_eeprom_seq #(.MAX_LEN(MAX_LEN), .TWR_CYC(TWR), .ACC_TMO(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .m_ctrl(m_ctrl), .m_wdata(m_wdata), .m_start(m_start), .m_rdata(m_rdata), .m_idle(m_idle)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ctrl(input logic rw, input logic [7:0] a);
    return {15'h0, rw, 1'b0, 7'h50, a};
  endfunction

  task automatic plan_read(input logic [7:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] x;
      x = a + 8'(i);
      exp_q.push_back('{ctrl: exp_ctrl(1'b1, x), wdata: 32'h0, is_wr: 1'b1 ^ 1'b1});
      rd_q.push_back(x ^ 8'hA5);
    end
  endtask

  task automatic plan_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{ctrl: exp_ctrl(1'b0, a), wdata: {24'h0, d}, is_wr: 1'b1});
    wq.push_back(d);
  endtask

  task automatic send_cmd(input logic rw, input logic [7:0] a, input logic [LW-1:0] l);
    @(negedge aclk);
    chk("cmd_ready_idle", {31'h0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_len = l;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      if (done) begin at = cyc; break; end
      @(negedge aclk);
    end
    chk("done_seen", {31'h0, at >= 0}, 1);
  endtask

  task automatic wait_idle(input logic lvl, input int budget);
    int ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge aclk);
      if (m_idle === lvl) begin ok = 1; break; end
    end
    chk("idle_wait", ok, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_flags"}, {26'h0, cmd_ready, wr_ready, rd_valid, done, err, m_start}, 32'h20);
    chk({tag, "_rd_data"}, {24'h0, rd_data}, 0);
    chk({tag, "_m_ctrl"}, m_ctrl, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
  endtask

  // Behavioural master: idle drops 3 cycles after start, rises 40 cycles later.
  initial begin
    exp_t e;
    m_idle = 1'b1; m_rdata = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_idle = 1'b1; mbusy = 0; mcnt = 0; prev_wr = 0;
      end else begin
        if (done) prev_wr = 0;
        if (mbusy) begin
          chk("start_while_busy", {31'h0, m_start}, 0);
          mcnt++;
          if (mcnt == 3) m_idle = 1'b0;
          else if (mcnt == 43) begin m_idle = 1'b1; mbusy = 0; last_rise = cyc; end
        end else if (m_start) begin
          starts++;
          last_start = cyc;
          if (prev_wr) chk("twr_gap", cyc - last_rise, TWR + 2);
          if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("m_ctrl", m_ctrl, e.ctrl);
            if (e.is_wr) chk("m_wdata", m_wdata, e.wdata);
          end
          prev_wr = !m_ctrl[16];
          if (!hang) begin
            mbusy = 1; mcnt = 0;
            m_rdata = {24'h0, m_ctrl[7:0] ^ 8'hA5};
          end
        end
      end
    end
  end

  initial begin
    bit hs;
    hs = 0; wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge aclk);
      if (hs && wq.size() > 0) void'(wq.pop_front());
      wr_valid = (wq.size() > 0);
      wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
      #1 hs = aresetn && wr_valid && wr_ready;
    end
  end

  initial begin
    forever begin
      @(negedge aclk);
      #1;
      if (aresetn && rd_valid && rd_ready) begin
        if (rd_q.size() == 0) chk("unexpected_rd", 1, 0);
        else chk("rd_data", {24'h0, rd_data}, {24'h0, rd_q.pop_front()});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int at, s0;
    logic [7:0] v;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0; rd_ready = 1'b1;
    repeat (3) @(negedge aclk);
    check_reset("reset");
    #2 aresetn = 1'b1;

    // Write burst 0x10 x3
    s0 = starts;
    plan_write(8'h10, 8'h11); plan_write(8'h11, 8'h22); plan_write(8'h12, 8'h33);
    send_cmd(1'b0, 8'h10, LW'(3));
    wait_done(2000, at);
    chk("wr_final_twr", at - last_rise, TWR + 1);
    chk("wr_starts", starts - s0, 3);
    chk("wr_err", {31'h0, err}, 0);
    @(negedge aclk);
    chk("cmd_ready_after_done", {30'h0, cmd_ready, done}, 32'h2);

    // Read burst with address wrap
    s0 = starts;
    plan_read(8'hFE, 4);
    send_cmd(1'b1, 8'hFE, LW'(4));
    wait_done(2000, at);
    chk("rd_starts", starts - s0, 4);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("rd_err", {31'h0, err}, 0);

    // Read with consumer stalled on byte 0
    rd_ready = 1'b0;
    plan_read(8'h30, 2);
    send_cmd(1'b1, 8'h30, LW'(2));
    for (int n = 0; n < 200 && !rd_valid; n++) @(negedge aclk);
    chk("stall_rd_valid", {31'h0, rd_valid}, 1);
    v = rd_data;
    chk("stall_first_byte", {24'h0, v}, 32'h95);
    s0 = starts;
    for (int n = 0; n < 100; n++) begin
      @(negedge aclk);
      chk("stall_hold", {23'h0, rd_valid, rd_data}, {23'h0, 1'b1, v});
    end
    chk("stall_no_restart", starts, s0);
    rd_ready = 1'b1;
    wait_done(2000, at);
    chk("stall_starts", starts - s0, 1);

    // Master never leaves idle
    hang = 1;
    s0 = starts;
    exp_q.push_back('{ctrl: exp_ctrl(1'b1, 8'h40), wdata: 32'h0, is_wr: 1'b0});
    send_cmd(1'b1, 8'h40, LW'(3));
    wait_done(2000, at);
    chk("tmo_latency", at - last_start, TMO + 1);
    chk("tmo_err", {31'h0, err}, 1);
    repeat (50) @(negedge aclk);
    chk("tmo_no_more_starts", starts - s0, 1);
    chk("tmo_err_sticky", {31'h0, err}, 1);
    hang = 0;
    plan_read(8'h50, 1);
    send_cmd(1'b1, 8'h50, LW'(1));
    chk("err_cleared", {31'h0, err}, 0);
    wait_done(2000, at);
    chk("after_tmo_err", {31'h0, err}, 0);

    // Bad lengths
    s0 = starts;
    send_cmd(1'b0, 8'h20, LW'(0));
    chk("len0_done", {30'h0, done, err}, 32'h3);
    @(negedge aclk);
    chk("len0_after", {30'h0, cmd_ready, done}, 32'h2);
    send_cmd(1'b0, 8'h20, LW'(MAX_LEN + 1));
    chk("len17_done", {30'h0, done, err}, 32'h3);
    repeat (10) @(negedge aclk);
    chk("badlen_no_starts", starts - s0, 0);

    // Reset while the master is mid-transaction
    plan_read(8'h60, 2);
    send_cmd(1'b1, 8'h60, LW'(2));
    wait_idle(1'b0, 200);
    repeat (5) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_reset("rst_wait_done");
    exp_q.delete(); rd_q.delete();
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;

    // Reset during write-cycle hold-off
    plan_write(8'h70, 8'h77);
    send_cmd(1'b0, 8'h70, LW'(1));
    wait_idle(1'b0, 200);
    wait_idle(1'b1, 200);
    repeat (5) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_reset("rst_twr");
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    chk("wq_drained", wq.size(), 0);

    s0 = starts;
    plan_read(8'h80, 2);
    send_cmd(1'b1, 8'h80, LW'(2));
    wait_done(2000, at);
    chk("post_rst_starts", starts - s0, 2);
    chk("post_rst_err", {31'h0, err}, 0);
    chk("post_rst_queues", exp_q.size() + rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
